// File: rtl/parity_frame_tx.sv
// parity_frame_tx: accepts a data word plus its parity bit and enable over a
// valid/ready handshake. It checks the parity bit against the data word, then
// sends one serial frame: a start bit, the data bits LSB first, the parity bit
// as received, and a stop bit. Each bit is held for CLKS_PER_BIT clocks.
module parity_frame_tx #(
    parameter int DATA_W       = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              enable_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic              par_err
);

    // The counters get at least one bit so that the degenerate
    // CLKS_PER_BIT=1 and DATA_W=1 cases still produce legal vectors.
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [DIV_W-1:0]  div_reg;
    logic [DIV_W-1:0]  div_next;
    logic [BIT_W-1:0]  bit_reg;
    logic [BIT_W-1:0]  bit_next;
    logic [DATA_W-1:0] data_reg;
    logic              parity_reg;
    logic              par_err_reg;
    logic              accept;
    logic              slot_end;

    // The enable input only affects the parity check made at accept time.
    // It is therefore folded into par_err_reg instead of being stored.
    // While rst is high, in_ready is forced low.
    assign in_ready = (state_reg == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign slot_end = (div_reg == DIV_LAST);
    assign par_err  = par_err_reg;

    // State, divider, bit counter and hold registers.
    // A reset mid-frame aborts the frame at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_reg     <= '0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            par_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            if (accept) begin
                data_reg    <= data_in;
                parity_reg  <= parity_in;
                par_err_reg <= (parity_in != (enable_in & ^data_in));
            end
        end
    end

    // Next-state logic and line/status decode.
    // The divider returns to 0 at the end of every bit slot, so every state
    // change starts with a fresh divider count.
    always_comb begin
        state_next = state_reg;
        div_next   = slot_end ? '0 : div_reg + 1'b1;
        bit_next   = bit_reg;
        tx_out     = 1'b1;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                busy     = 1'b0;
                div_next = '0;
                bit_next = '0;
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                tx_out = 1'b0;
                if (slot_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_out = data_reg[bit_reg];
                if (slot_end) begin
                    if (bit_reg == BIT_LAST) begin
                        state_next = PARITY;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                tx_out = parity_reg;
                if (slot_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (slot_end) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Testbench for parity_frame_tx.
// Directed scenarios come first, then randomized frames, some of them sent
// back to back. Expected line values come from a frame model built with
// plain arithmetic.
module tb_parity_frame_tx;

    localparam int DW  = 3;
    localparam int CPB = 4;
    localparam int FRAME_CYCLES = (DW + 3) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          parity_in;
    logic          enable_in;
    logic          in_valid;
    logic          in_ready;
    logic          tx_out;
    logic          busy;
    logic          frame_done;
    logic          par_err;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_par_err = 1'b0;

    parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .parity_in  (parity_in),
        .enable_in  (enable_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    // A mismatch is counted and reported on a FAIL line.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for one frame: the line value in cycle c after accept,
    // where c runs from 1 to FRAME_CYCLES.
    function automatic logic model_line(input logic [DW-1:0] d, input logic p, input int c);
        int slot;
        slot = (c - 1) / CPB;
        if (slot == 0)       return 1'b0;
        else if (slot <= DW) return d[slot-1];
        else if (slot == DW + 1) return p;
        else                 return 1'b1;
    endfunction

    // Reference parity check: an error when the received bit differs from
    // even parity over the data word, gated by enable.
    function automatic logic model_err(input logic [DW-1:0] d, input logic e, input logic p);
        logic expect_p;
        expect_p = e ? logic'($countones(d) % 2) : 1'b0;
        return p != expect_p;
    endfunction

    // Present one word with in_valid high and clock it in.
    task automatic accept(input logic [DW-1:0] d, input logic e, input logic p);
        data_in   = d;
        enable_in = e;
        parity_in = p;
        in_valid  = 1'b1;
        check("ready_before_accept", in_ready, 1'b1);
        step();
        exp_par_err = model_err(d, e, p);
    endtask

    // Check every cycle of an accepted frame, then the idle cycle after it.
    // Junk is driven on the inputs during the frame. From mid-frame on, the
    // inputs carry the next word. If keep is set, in_valid stays high so that
    // the next word is accepted on the idle cycle.
    task automatic run_frame(input logic [DW-1:0] d, input logic p, input logic keep,
                             input logic [DW-1:0] nd, input logic ne, input logic np);
        for (int c = 1; c <= FRAME_CYCLES; c++) begin
            in_valid = keep;
            if (c < 2 * CPB) begin
                data_in   = DW'($urandom);
                enable_in = 1'($urandom);
                parity_in = 1'($urandom);
            end else begin
                data_in   = nd;
                enable_in = ne;
                parity_in = np;
            end
            check($sformatf("tx_c%0d_d%0h", c, d), tx_out, model_line(d, p, c));
            check($sformatf("busy_c%0d", c), busy, 1'b1);
            check($sformatf("ready_c%0d", c), in_ready, 1'b0);
            check($sformatf("done_c%0d", c), frame_done, (c == FRAME_CYCLES) ? 1'b1 : 1'b0);
            check($sformatf("par_err_c%0d", c), par_err, exp_par_err);
            step();
        end
        check("idle_tx", tx_out, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", in_ready, 1'b1);
        check("idle_done", frame_done, 1'b0);
        check("idle_par_err_hold", par_err, exp_par_err);
        if (!keep) begin
            in_valid = 1'b0;
        end
    endtask

    logic [DW-1:0] rd [0:16];
    logic          re [0:16];
    logic          rp [0:16];
    logic          rk [0:15];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        parity_in = 1'b0;
        enable_in = 1'b0;

        // Hold reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx", tx_out, 1'b1);
            check("rst_ready", in_ready, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", frame_done, 1'b0);
            check("rst_par_err", par_err, 1'b0);
        end
        rst = 1'b0;

        // Ten idle cycles with in_valid low.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_tx", tx_out, 1'b1);
            check("idle_ready", in_ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_done", frame_done, 1'b0);
        end

        // Single frame with correct parity.
        accept(3'b001, 1'b1, 1'b1);
        check("single_par_err_model", exp_par_err, 1'b0);
        run_frame(3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);

        // Parity mismatch. par_err stays set after frame_done.
        accept(3'b011, 1'b1, 1'b1);
        run_frame(3'b011, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mismatch_hold", par_err, 1'b1);
        end

        // Enable low, with a good parity bit and then a bad one.
        accept(3'b111, 1'b0, 1'b0);
        run_frame(3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        check("en_low_ok", par_err, 1'b0);
        accept(3'b111, 1'b0, 1'b1);
        run_frame(3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        check("en_low_bad", par_err, 1'b1);

        // Back to back: in_valid is held high across both frames.
        accept(3'b100, 1'b1, 1'b1);
        run_frame(3'b100, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1);
        accept(3'b010, 1'b1, 1'b1);
        run_frame(3'b010, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);

        // Reset during the bit-1 data slot. The line must go high at once.
        accept(3'b110, 1'b1, 1'b1);
        for (int c = 1; c < 10; c++) begin
            in_valid = 1'b0;
            step();
        end
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_tx_bit1", tx_out, 1'b1);
        @(negedge clk);
        check("pre_rst_busy_neg", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_tx", tx_out, 1'b1);
        check("async_rst_ready", in_ready, 1'b0);
        check("async_rst_par_err", par_err, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_no_done", frame_done, 1'b0);
            check("rst_tx_hold", tx_out, 1'b1);
        end
        rst = 1'b0;
        step();
        check("post_rst_ready", in_ready, 1'b1);
        accept(3'b101, 1'b1, 1'b0);
        run_frame(3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);

        // Randomized frames. Some are chained back to back with in_valid held.
        for (int i = 0; i <= 16; i++) begin
            rd[i] = DW'($urandom);
            re[i] = 1'($urandom);
            rp[i] = 1'($urandom);
        end
        for (int i = 0; i < 16; i++) begin
            rk[i] = (i == 15) ? 1'b0 : 1'($urandom);
        end
        for (int i = 0; i < 16; i++) begin
            accept(rd[i], re[i], rp[i]);
            run_frame(rd[i], rp[i], rk[i], rd[i+1], re[i+1], rp[i+1]);
            if (!rk[i]) begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
